muldiv_unit: RTL and testbench

- Multi-cycle integer multiply/divide unit for the EX stage of the pipelined MIPS core.
- Executes MULT, MULTU, DIV and DIVU iteratively, and MTHI/MTLO in one cycle.
- Holds the architectural HI/LO registers.
- Sits directly upstream of the EX result mux2, which selects between the ALU result and HI/LO for MFHI/MFLO.
- Drives `busy` to the hazard unit, which stalls MFHI/MFLO and a new mul/div while an operation is in flight.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/muldiv_step.sv | 29 ++
 rtl/muldiv_unit.sv | 165 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: op codes, FSM states
// and the divide-by-zero quotient constant.
package mips_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } md_state_e;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the shared {upper, lower} accumulator: shift-add
// multiply (shift right) or restoring divide (shift left, trial subtract).
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div_i,
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [WIDTH-1:0]   opb_i,
    output logic [2*WIDTH-1:0] acc_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opb_i} : '0);
        // Remainder after the left shift can need WIDTH+1 bits before the subtract.
        rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
        diff   = rem_sh - {1'b0, opb_i};
        if (!is_div_i)
            acc_o = {sum, acc_i[WIDTH-1:1]};
        else if (!diff[WIDTH])
            acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
        else
            acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding HI/LO. Define MULDIV_FAST_MULT_EN
// to compute multiplies in a single edge with a full-width multiplier.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic             flush,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic               div0_q, div0_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               signed_op, a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;
    logic [2*WIDTH-1:0] prod;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div_i (is_div_q),
        .acc_i    (acc_q),
        .opb_i    (opb_q),
        .acc_o    (acc_step)
    );

    always_comb begin
        signed_op = !op[0];
        a_neg     = signed_op && rs_val[WIDTH-1];
        b_neg     = signed_op && rt_val[WIDTH-1];
        a_mag     = a_neg ? -rs_val : rs_val;
        b_mag     = b_neg ? -rt_val : rt_val;
        prod      = neg_q ? -acc_q : acc_q;
        quo       = acc_q[WIDTH-1:0];
        rem       = acc_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        div0_d    = div0_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    case (md_op_e'(op))
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            is_div_d  = op[1];
                            neg_d     = a_neg ^ b_neg;
                            rem_neg_d = a_neg;
                            div0_d    = op[1] && (rt_val == '0);
                            opb_d     = b_mag;
                            // Dividend or multiplier starts in the low half for both algorithms.
                            acc_d     = {{WIDTH{1'b0}}, a_mag};
                            cnt_d     = CNT_W'(WIDTH);
                            busy_d    = 1'b1;
                            state_d   = ST_CALC;
`ifdef MULDIV_FAST_MULT_EN
                            if (!op[1]) begin
                                acc_d   = (2*WIDTH)'(a_mag) * (2*WIDTH)'(b_mag);
                                state_d = ST_FIX;
                            end
`endif
                        end
                        default: ;
                    endcase
                end
            end
            ST_CALC: begin
                if (flush) begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    acc_d = acc_step;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1))
                        state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                if (!flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        // Remainder magnitude equals |dividend| on /0, so the sign fix restores rs_val.
                        lo_d = div0_q ? WIDTH'(DIV0_LO) : (neg_q ? -quo : quo);
                        hi_d = rem_neg_q ? -rem : rem;
                    end else begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            div0_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            is_div_q  <= is_div_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            div0_q    <= div0_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed plus randomized checks of muldiv_unit against a plain-arithmetic model.
module tb_muldiv_unit;

    localparam int W = 32;
    localparam logic [2:0] MULT = 3'd0, MULTU = 3'd1, DIV = 3'd2, DIVU = 3'd3,
                           MTHI = 3'd4, MTLO = 3'd5;
`ifdef MULDIV_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         flush = 1'b0;
    logic [2:0]   op = 3'd0;
    logic [W-1:0] rs_val = '0;
    logic [W-1:0] rt_val = '0;
    logic [W-1:0] hi, lo;
    logic         busy, done;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .flush(flush),
        .rs_val(rs_val), .rt_val(rt_val), .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // HI/LO as the ISA defines them, using native 64-bit arithmetic.
    task automatic model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] h, output logic [W-1:0] l);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h = '0;
        l = '0;
        if (o == MULT || o == MULTU) begin
            p = (o == MULT) ? sa * sb : {32'b0, a} * {32'b0, b};
            h = p[63:32];
            l = p[31:0];
        end else if (b == '0) begin
            h = a;
            l = 32'hFFFF_FFFF;
        end else if (o == DIV) begin
            q = sa / sb;
            r = sa % sb;
            l = q[31:0];
            h = r[31:0];
        end else begin
            l = a / b;
            h = a % b;
        end
    endtask

    task automatic start_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lat, input logic [W-1:0] eh,
                             input logic [W-1:0] el);
        int cyc;
        logic bok;
        cyc = 0;
        bok = (busy === 1'b1);
        while (done !== 1'b1 && cyc < lat + 10) begin
            @(posedge clk); #1;
            cyc++;
            if (done !== 1'b1 && busy !== 1'b1) bok = 1'b0;
        end
        chk({tag, "_lat"}, 64'(cyc), 64'(lat));
        chk({tag, "_hi"}, 64'(hi), 64'(eh));
        chk({tag, "_lo"}, 64'(lo), 64'(el));
        chk({tag, "_busy_hold"}, 64'(bok), 64'(1));
        chk({tag, "_busy_end"}, 64'(busy), 64'(0));
        @(posedge clk); #1;
        chk({tag, "_done_fall"}, 64'(done), 64'(0));
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        logic [W-1:0] eh, el;
        model(o, a, b, eh, el);
        start_op(o, a, b);
        wait_done(tag, o[1] ? DIV_LAT : MUL_LAT, eh, el);
    endtask

    initial begin
        logic [W-1:0] corners [6];
        logic [W-1:0] a, b, ph, pl;
        logic [2:0]   o;
        corners = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h7FFF_FFFF, 32'hFFFF_FFFE};

        #12;
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        @(negedge clk) rst_n = 1'b1;

        run_op("mult_neg", MULT, 32'hFFFF_FFFD, 32'd7);
        chk("mult_neg_const", {32'(hi), 32'(lo)}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk("multu_max_const", {32'(hi), 32'(lo)}, 64'hFFFF_FFFE_0000_0001);
        run_op("div_neg", DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div_neg_const", {32'(hi), 32'(lo)}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_zero", DIVU, 32'd100, 32'd0);
        chk("divu_zero_const", {32'(hi), 32'(lo)}, {32'd100, 32'hFFFF_FFFF});
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("div_ovf_const", {32'(hi), 32'(lo)}, 64'h0000_0000_8000_0000);
        run_op("div_zero_neg", DIV, 32'hFFFF_FF00, 32'd0);

        // MTHI takes one edge, then a DIV with a stray MTLO issued mid-flight.
        start_op(MTHI, 32'h1234_5678, 32'd0);
        chk("mthi_hi", 64'(hi), 64'h1234_5678);
        chk("mthi_busy", 64'(busy), 64'(0));
        chk("mthi_done", 64'(done), 64'(0));
        pl = lo;
        start_op(DIV, 32'd10, 32'd3);
        repeat (5) @(posedge clk);
        start_op(MTLO, 32'hDEAD_BEEF, 32'd0);
        chk("busy_start_lo", 64'(lo), 64'(pl));
        chk("busy_start_busy", 64'(busy), 64'(1));
        wait_done("div_10_3", DIV_LAT - 6, 32'd1, 32'd3);

        // Flush at E11 of a DIV, then restart at E12.
        ph = hi; pl = lo;
        start_op(DIV, 32'd50, 32'd5);
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'(0));
        chk("flush_done", 64'(done), 64'(0));
        chk("flush_hilo", {32'(hi), 32'(lo)}, {32'(ph), 32'(pl)});
        run_op("after_flush", DIV, 32'd50, 32'd5);

        // Flush wins over a same-cycle start from IDLE.
        ph = hi;
        @(negedge clk);
        flush = 1'b1; start = 1'b1; op = MTHI; rs_val = 32'hAAAA_AAAA;
        @(posedge clk); #1;
        op = DIV;
        @(posedge clk); #1;
        flush = 1'b0; start = 1'b0;
        chk("flush_start_hi", 64'(hi), 64'(ph));
        chk("flush_start_busy", 64'(busy), 64'(0));

        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(0, 3));
            a = $urandom();
            b = $urandom();
            case ($urandom_range(0, 3))
                0: a = corners[$urandom_range(0, 5)];
                1: b = corners[$urandom_range(0, 5)];
                2: b = 32'($urandom_range(0, 9));
                default: ;
            endcase
            run_op($sformatf("rnd%0d_op%0d", i, o), o, a, b);
        end

        // Asynchronous reset in the middle of an operation.
        start_op(MTHI, 32'd5, 32'd0);
        start_op(MTLO, 32'd6, 32'd0);
        start_op(MULT, 32'h0001_2345, 32'h0000_0777);
        repeat (15) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_hi", 64'(hi), 64'(0));
        chk("arst_lo", 64'(lo), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        @(negedge clk) rst_n = 1'b1;
        run_op("mult_6x7", MULT, 32'd6, 32'd7);
        chk("mult_6x7_const", {32'(hi), 32'(lo)}, 64'd42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
